logic_engine_responder: RTL and testbench

Synthesizable responder for the CPU's logic-engine request/acknowledge interface (logic_req/logic_addr -> logic_ack/logic_data). It replaces the behavioural bench model with a real block in the SoC. On each request it waits a fixed, parameterised latency, then returns a word from a small configurable result table. It also keeps the transaction and abort statistics that the CPU status path reads.

---
 rtl/logic_engine_pkg.sv | 21 ++
 rtl/logic_result_table.sv | 33 +++
 rtl/logic_engine_responder.sv | 114 +++++++++++
 tb/tb_logic_engine_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_engine_pkg.sv
// Shared types, constants and helpers for the logic-engine responder.
package logic_engine_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    ACK       = 2'd2,
    WAIT_DROP = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_DATA = 32'hABCD_1234;
  localparam logic [31:0] ERR_DATA     = 32'hDEAD_BEEF;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] lim
  );
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/logic_result_table.sv
// Result table: DEPTH x 32 register file, one sync write port,
// one combinational read port, reset to a fixed init word.
module logic_result_table
  import logic_engine_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter logic [31:0] INIT  = 32'hABCD_1234,
  localparam int unsigned IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] ridx,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= INIT;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/logic_engine_responder.sv
// Logic-engine responder: fixed-latency req/ack slave returning
// words from a configurable table, with transaction statistics.
module logic_engine_responder
  import logic_engine_pkg::*;
#(
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned DEPTH        = 16,
  parameter logic [31:0] DEFAULT_DATA = logic_engine_pkg::DEFAULT_DATA,
  parameter logic [31:0] ERR_DATA     = logic_engine_pkg::ERR_DATA,
  localparam int unsigned IW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [31:0]   addr,
  output logic          ack,
  output logic [31:0]   data,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [31:0]   cfg_wdata,
  output logic          busy,
  output logic          err_addr,
  output logic [31:0]   req_count,
  output logic [15:0]   abort_count
);

  state_t      state;
  state_t      state_n;
  logic [31:0] addr_q;
  logic [7:0]  cnt;
  logic [31:0] rdata;
  logic        in_range;

  logic_result_table #(
    .DEPTH (DEPTH),
    .INIT  (DEFAULT_DATA)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we),
    .widx  (cfg_idx),
    .wdata (cfg_wdata),
    .ridx  (addr_q[IW+1:2]),
    .rdata (rdata)
  );

  assign in_range = (addr_q[31:IW+2] == '0);
  assign ack      = (state == ACK);
  assign busy     = (state == BUSY) || (state == ACK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req) state_n = BUSY;
      end
      BUSY: begin
        if (!req) state_n = IDLE;
        else if (cnt == 8'd0) state_n = ACK;
      end
      ACK: begin
        state_n = req ? WAIT_DROP : IDLE;
      end
      WAIT_DROP: begin
        if (!req) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Table read sees pre-write contents, so a same-edge cfg write
  // to the served index returns the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      cnt         <= '0;
      data        <= '0;
      err_addr    <= 1'b0;
      req_count   <= '0;
      abort_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            addr_q <= addr;
            cnt    <= 8'(LATENCY);
          end
        end
        BUSY: begin
          if (!req) begin
            abort_count <= 16'(sat_inc({16'h0, abort_count},
                                       32'h0000_FFFF));
          end else if (cnt == 8'd0) begin
            data      <= in_range ? rdata : ERR_DATA;
            err_addr  <= err_addr | ~in_range;
            req_count <= sat_inc(req_count, 32'hFFFF_FFFF);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_engine_responder.sv
// Directed self-checking bench for logic_engine_responder.
module tb_logic_engine_responder;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [31:0] cfg_wdata;
  logic        busy;
  logic        err_addr;
  logic [31:0] req_count;
  logic [15:0] abort_count;

  int checks;
  int failures;

  logic_engine_responder #(
    .LATENCY (2),
    .DEPTH   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .addr        (addr),
    .ack         (ack),
    .data        (data),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_wdata   (cfg_wdata),
    .busy        (busy),
    .err_addr    (err_addr),
    .req_count   (req_count),
    .abort_count (abort_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raise req, wait for ack (bounded), hold, then drop and settle.
  // lat counts edges from the capturing edge up to the ack edge inclusive.
  task automatic run_req(input logic [31:0] a, input int hold,
                         output int lat);
    req  = 1'b1;
    addr = a;
    lat  = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack) begin
        lat = i;
        break;
      end
    end
    for (int i = 0; i < hold; i++) tick();
    req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = 1'b0; addr = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_wdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ack !== 1'b0) begin
      failures++; $display("FAIL reset_ack got=%b exp=0", ack);
    end
    checks++;
    if (data !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", data);
    end
    checks++;
    if (busy !== 1'b0 || err_addr !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b err=%b exp=0,0", busy, err_addr);
    end
    checks++;
    if (req_count !== 32'h0 || abort_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_counts req=%0d abort=%0d exp=0,0",
               req_count, abort_count);
    end
  endtask

  task automatic test_basic;
    logic [4:0] ack_seq;
    logic [4:0] busy_seq;
    int acks;
    int lat;
    req = 1'b1; addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      ack_seq[i]  = ack;
      busy_seq[i] = busy;
    end
    checks++;
    if (ack_seq !== 5'b01000) begin
      failures++; $display("FAIL basic_ack_seq got=%b exp=01000", ack_seq);
    end
    checks++;
    if (busy_seq !== 5'b01111) begin
      failures++; $display("FAIL basic_busy_seq got=%b exp=01111", busy_seq);
    end
    checks++;
    if (data !== 32'hABCD1234 || req_count !== 32'd1) begin
      failures++;
      $display("FAIL basic_data got=%h cnt=%0d exp=abcd1234 cnt=1",
               data, req_count);
    end
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack) acks++;
    end
    checks++;
    if (acks !== 0 || busy !== 1'b0 || dut.state !== 2'd3) begin
      failures++;
      $display("FAIL held_req acks=%0d busy=%b state=%0d exp=0,0,3",
               acks, busy, dut.state);
    end
    req = 1'b0;
    tick();
    run_req(32'h4, 0, lat);
    checks++;
    if (lat !== 4 || req_count !== 32'd2) begin
      failures++;
      $display("FAIL second_req lat=%0d cnt=%0d exp=4,2", lat, req_count);
    end
  endtask

  task automatic test_table;
    int lat;
    cfg_we = 1'b1; cfg_idx = 4'd3; cfg_wdata = 32'h12345678;
    tick();
    cfg_we = 1'b0;
    run_req(32'hC, 0, lat);
    checks++;
    if (lat !== 4 || data !== 32'h12345678) begin
      failures++;
      $display("FAIL table_cfg lat=%0d data=%h exp=4,12345678", lat, data);
    end
    run_req(32'hF, 0, lat);
    checks++;
    if (data !== 32'h12345678 || req_count !== 32'd4) begin
      failures++;
      $display("FAIL table_lowbits data=%h cnt=%0d exp=12345678,4",
               data, req_count);
    end
    checks++;
    if (err_addr !== 1'b0) begin
      failures++; $display("FAIL table_err got=%b exp=0", err_addr);
    end
  endtask

  task automatic test_out_of_range;
    int lat;
    run_req(32'h40, 0, lat);
    checks++;
    if (data !== 32'hDEADBEEF || err_addr !== 1'b1) begin
      failures++;
      $display("FAIL oor data=%h err=%b exp=deadbeef,1", data, err_addr);
    end
    run_req(32'h0, 2, lat);
    checks++;
    if (data !== 32'hABCD1234 || err_addr !== 1'b1 ||
        req_count !== 32'd6) begin
      failures++;
      $display("FAIL oor_sticky data=%h err=%b cnt=%0d exp=abcd1234,1,6",
               data, err_addr, req_count);
    end
  endtask

  task automatic test_abort;
    int acks;
    acks = 0;
    req = 1'b1; addr = 32'h8;
    tick();
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack) acks++;
    end
    checks++;
    if (acks !== 0 || abort_count !== 16'd1 || req_count !== 32'd6) begin
      failures++;
      $display("FAIL abort acks=%0d abort=%0d cnt=%0d exp=0,1,6",
               acks, abort_count, req_count);
    end
    checks++;
    if (busy !== 1'b0 || data !== 32'hABCD1234) begin
      failures++;
      $display("FAIL abort_idle busy=%b data=%h exp=0,abcd1234", busy, data);
    end
  endtask

  task automatic test_corner_rbw;
    int lat;
    req = 1'b1; addr = 32'h8;
    tick(); tick(); tick();
    cfg_we = 1'b1; cfg_idx = 4'd2; cfg_wdata = 32'h55AA55AA;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (ack !== 1'b1 || data !== 32'hABCD1234) begin
      failures++;
      $display("FAIL rbw_old ack=%b data=%h exp=1,abcd1234", ack, data);
    end
    req = 1'b0;
    tick();
    run_req(32'h8, 0, lat);
    checks++;
    if (data !== 32'h55AA55AA || req_count !== 32'd8) begin
      failures++;
      $display("FAIL rbw_new data=%h cnt=%0d exp=55aa55aa,8",
               data, req_count);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    req = 1'b1; addr = 32'hC;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || data !== 32'h0 ||
        err_addr !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset ack=%b busy=%b data=%h err=%b exp=0,0,0,0",
               ack, busy, data, err_addr);
    end
    checks++;
    if (req_count !== 32'h0 || abort_count !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset_cnt req=%0d abort=%0d exp=0,0",
               req_count, abort_count);
    end
    req = 1'b0;
    rst_n = 1'b1;
    tick();
    run_req(32'hC, 0, lat);
    checks++;
    if (lat !== 4 || data !== 32'hABCD1234 || req_count !== 32'd1) begin
      failures++;
      $display("FAIL mid_reset_table lat=%0d data=%h cnt=%0d exp=4,abcd1234,1",
               lat, data, req_count);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req = 1'b0;
    addr = '0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_wdata = '0;
    test_reset();
    test_basic();
    test_table();
    test_out_of_range();
    test_abort();
    test_corner_rbw();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
